// File: rtl/key_event_if.sv
`default_nettype none
// ============================================================================
// Module      : key_event_if
// Description : Key-event bus from the keypad arbiter to the code-entry FSM
//               and the display logic.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_event_if;
  logic       key_valid;     // 1-cycle pulse: accepted key event
  logic [3:0] key_code;      // 0-9 digit, 4'hA ok, 4'hB clear
  logic       key_conflict;  // 1-cycle pulse: multi-key press rejected
  logic       key_held;      // a press (accepted or rejected) is still down
  logic [7:0] event_cnt;     // running count of key_valid pulses

  modport master (
    output key_valid,
    output key_code,
    output key_conflict,
    output key_held,
    output event_cnt
  );

  modport slave (
    input key_valid,
    input key_code,
    input key_conflict,
    input key_held,
    input event_cnt
  );
endinterface
`default_nettype wire

// File: rtl/key_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : key_event_arbiter
// Description : Synchronises and debounces 12 raw keypad buttons, rejects
//               simultaneous presses and enforces press-release so that each
//               physical press produces exactly one 1-cycle key event.
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_arbiter #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic [11:0] key_in,
  key_event_if.master      ev
);

  localparam logic [0:0]       c_st_idle  = 1'b0;
  localparam logic [0:0]       c_st_held  = 1'b1;
  localparam logic [CNT_W-1:0] c_deb_max  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [3:0]       c_code_clr = 4'hB;

  logic [11:0]      r_sync1;
  logic [11:0]      r_sync2;
  logic [11:0]      r_samp;
  logic [CNT_W-1:0] r_cnt;
  logic [11:0]      r_deb;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;

  logic             w_onehot;
  logic [3:0]       w_idx;
  logic             w_valid_nxt;
  logic             w_conflict_nxt;
  logic [3:0]       w_code_nxt;

  logic             r_valid;
  logic             r_conflict;
  logic [3:0]       r_code;
  logic [7:0]       r_event_cnt;

  // Two-flop synchroniser for every raw button bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  // Whole-vector debounce: any change restarts the count; the debounced
  // vector follows only after the count has saturated on a stable value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_samp <= '0;
      r_cnt  <= '0;
      r_deb  <= '0;
    end else begin
      r_samp <= r_sync2;
      if (r_sync2 != r_samp) begin
        r_cnt <= '0;
      end else if (r_cnt == c_deb_max) begin
        r_deb <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Lowest set bit index; only meaningful when exactly one bit is set.
  always_comb begin
    w_idx    = 4'd0;
    w_onehot = (r_deb != 12'd0) && ((r_deb & (r_deb - 12'd1)) == 12'd0);
    for (int i = 10; i >= 0; i--) begin
      if (r_deb[i]) begin
        w_idx = 4'(i);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: leave IDLE on any press, return only on full release.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (r_deb != 12'd0) w_state_nxt = c_st_held;
      c_st_held: if (r_deb == 12'd0) w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  // FSM outputs: classify a fresh press; clear wins over any other key.
  always_comb begin
    w_valid_nxt    = 1'b0;
    w_conflict_nxt = 1'b0;
    w_code_nxt     = r_code;
    if (r_state == c_st_idle && r_deb != 12'd0) begin
      if (r_deb[11]) begin
        w_valid_nxt = 1'b1;
        w_code_nxt  = c_code_clr;
      end else if (w_onehot) begin
        w_valid_nxt = 1'b1;
        w_code_nxt  = w_idx;
      end else begin
        w_conflict_nxt = 1'b1;
      end
    end
  end

  // Registered event outputs and the wrapping event counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_conflict  <= 1'b0;
      r_code      <= 4'd0;
      r_event_cnt <= 8'd0;
    end else begin
      r_valid     <= w_valid_nxt;
      r_conflict  <= w_conflict_nxt;
      r_code      <= w_code_nxt;
      r_event_cnt <= r_event_cnt + 8'(w_valid_nxt);
    end
  end

  assign ev.key_valid    = r_valid;
  assign ev.key_conflict = r_conflict;
  assign ev.key_code     = r_code;
  assign ev.key_held     = (r_state == c_st_held);
  assign ev.event_cnt    = r_event_cnt;

endmodule
`default_nettype wire
